// File: rtl/riscv_defs_pkg.sv
// Shared definitions for the RISC-V fetch path: widths, the NOP encoding,
// the fetch packet carried through the skid buffer and output register.
package riscv_defs;

    localparam int NB_ADDR  = 32;
    localparam int NB_INSTR = 32;

    // addi x0, x0, 0
    localparam logic [NB_INSTR-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [NB_INSTR-1:0] instr;
        logic [NB_ADDR-1:0]  pc;
        logic                misaligned;
    } fetch_pkt_t;

    localparam int FETCH_PKT_W = $bits(fetch_pkt_t);

    // An instruction address is usable only when word aligned
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/riscv_skid_buffer.sv
// One-entry skid buffer: holds a single fetch response that arrived while the
// decode stage was stalling and the output register was already occupied.
module riscv_skid_buffer #(
    parameter int W = 1
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Next-state: flush wins, then push, then pop
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (i_push) begin
            valid_d = 1'b1;
            data_d  = i_data;
        end else if (i_pop) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Entry storage with synchronous reset
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            data_q  <= {W{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;

endmodule

// File: rtl/riscv_ifetch.sv
// Instruction-fetch stage: owns the PC, drives the 1-cycle synchronous imem,
// presents {instr, pc, pc+4} to decode over valid/ready, absorbs stalls with a
// one-entry skid buffer and discards wrong-path fetches on redirect.
// A fresh imem response is shown to decode in the cycle it arrives; it is only
// captured into the output register when decode does not take it right away.
module riscv_ifetch
    import riscv_defs::fetch_pkt_t;
    import riscv_defs::FETCH_PKT_W;
    import riscv_defs::INSTR_NOP;
    import riscv_defs::is_misaligned;
#(
    parameter int                 NB_ADDR  = riscv_defs::NB_ADDR,
    parameter int                 NB_INSTR = riscv_defs::NB_INSTR,
    parameter logic [NB_ADDR-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                i_clock,
    input  logic                i_reset,
    output logic [NB_ADDR-1:0]  o_imem_addr,
    output logic                o_imem_rd,
    input  logic [NB_INSTR-1:0] i_imem_data,
    input  logic                i_redirect_valid,
    input  logic [NB_ADDR-1:0]  i_redirect_target,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [NB_INSTR-1:0] o_instr,
    output logic [NB_ADDR-1:0]  o_pc,
    output logic [NB_ADDR-1:0]  o_pc_plus4,
    output logic                o_misaligned
);

    logic [NB_ADDR-1:0] pc_q, pc_d;
    logic               halt_q, halt_d;
    logic               inflight_q, inflight_d;
    logic               inflight_mis_q, inflight_mis_d;
    logic [NB_ADDR-1:0] inflight_pc_q, inflight_pc_d;
    logic [NB_ADDR-1:0] inflight_pc4_q, inflight_pc4_d;
    logic               out_valid_q, out_valid_d;
    fetch_pkt_t         out_pkt_q, out_pkt_d;
    logic [NB_ADDR-1:0] out_pc4_q, out_pc4_d;

    fetch_pkt_t resp_pkt_s;
    fetch_pkt_t skid_pkt_s;
    logic       skid_valid_s, skid_push_s, skid_pop_s, skid_flush_s;
    logic       show_resp_s, pres_valid_s, stall_s, issue_s, issue_mis_s;

    riscv_skid_buffer #(.W(FETCH_PKT_W)) u_skid (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_flush (skid_flush_s),
        .i_push  (skid_push_s),
        .i_pop   (skid_pop_s),
        .i_data  (resp_pkt_s),
        .o_valid (skid_valid_s),
        .o_data  (skid_pkt_s)
    );

    // Assemble the response packet; a misaligned pseudo-fetch carries a NOP
    always_comb begin
        resp_pkt_s.pc         = inflight_pc_q;
        resp_pkt_s.misaligned = inflight_mis_q;
        if (inflight_mis_q) begin
            resp_pkt_s.instr = INSTR_NOP;
        end else begin
            resp_pkt_s.instr = i_imem_data;
        end
    end

    // Handshake status and fetch-issue decision
    always_comb begin
        show_resp_s  = !out_valid_q && inflight_q;
        pres_valid_s = out_valid_q || inflight_q;
        stall_s      = pres_valid_s && !i_ready;
        issue_mis_s  = is_misaligned(pc_q[1:0]);
        issue_s      = !i_redirect_valid && !halt_q && !skid_valid_s && !(stall_s && inflight_q);
    end

    // Next-state for PC, in-flight tag, output register and skid control
    always_comb begin
        pc_d           = pc_q;
        halt_d         = halt_q;
        inflight_d     = inflight_q;
        inflight_mis_d = inflight_mis_q;
        inflight_pc_d  = inflight_pc_q;
        inflight_pc4_d = inflight_pc4_q;
        out_valid_d    = out_valid_q;
        out_pkt_d      = out_pkt_q;
        out_pc4_d      = out_pc4_q;
        skid_push_s    = 1'b0;
        skid_pop_s     = 1'b0;
        skid_flush_s   = 1'b0;
        if (i_redirect_valid) begin
            pc_d         = i_redirect_target;
            halt_d       = 1'b0;
            inflight_d   = 1'b0;
            out_valid_d  = 1'b0;
            skid_flush_s = 1'b1;
        end else begin
            if (issue_s) begin
                inflight_d     = 1'b1;
                inflight_pc_d  = pc_q;
                inflight_pc4_d = pc_q + NB_ADDR'(32'd4);
                inflight_mis_d = issue_mis_s;
                if (issue_mis_s) begin
                    halt_d = 1'b1;
                end else begin
                    pc_d = pc_q + NB_ADDR'(32'd4);
                end
            end else begin
                inflight_d = 1'b0;
            end
            if (out_valid_q) begin
                if (i_ready) begin
                    if (skid_valid_s) begin
                        out_pkt_d  = skid_pkt_s;
                        out_pc4_d  = skid_pkt_s.pc + NB_ADDR'(32'd4);
                        skid_pop_s = 1'b1;
                    end else if (inflight_q) begin
                        out_pkt_d = resp_pkt_s;
                        out_pc4_d = inflight_pc4_q;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end else begin
                    skid_push_s = inflight_q;
                end
            end else begin
                if (inflight_q && !i_ready) begin
                    out_valid_d = 1'b1;
                    out_pkt_d   = resp_pkt_s;
                    out_pc4_d   = inflight_pc4_q;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
        end
    end

    // State registers with synchronous reset taking priority
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pc_q           <= RESET_PC;
            halt_q         <= 1'b0;
            inflight_q     <= 1'b0;
            inflight_mis_q <= 1'b0;
            inflight_pc_q  <= {NB_ADDR{1'b0}};
            inflight_pc4_q <= {NB_ADDR{1'b0}};
            out_valid_q    <= 1'b0;
            out_pkt_q      <= '{instr: INSTR_NOP, pc: {NB_ADDR{1'b0}}, misaligned: 1'b0};
            out_pc4_q      <= {NB_ADDR{1'b0}};
        end else begin
            pc_q           <= pc_d;
            halt_q         <= halt_d;
            inflight_q     <= inflight_d;
            inflight_mis_q <= inflight_mis_d;
            inflight_pc_q  <= inflight_pc_d;
            inflight_pc4_q <= inflight_pc4_d;
            out_valid_q    <= out_valid_d;
            out_pkt_q      <= out_pkt_d;
            out_pc4_q      <= out_pc4_d;
        end
    end

    // Present the live imem response when the output register is empty
    always_comb begin
        if (show_resp_s) begin
            o_instr      = resp_pkt_s.instr;
            o_pc         = resp_pkt_s.pc;
            o_misaligned = resp_pkt_s.misaligned;
            o_pc_plus4   = inflight_pc4_q;
        end else begin
            o_instr      = out_pkt_q.instr;
            o_pc         = out_pkt_q.pc;
            o_misaligned = out_pkt_q.misaligned;
            o_pc_plus4   = out_pc4_q;
        end
    end

    assign o_valid     = pres_valid_s;
    assign o_imem_addr = pc_q;
    assign o_imem_rd   = issue_s && !issue_mis_s && !i_reset;

endmodule

// File: tb/tb_riscv_ifetch.sv
// Self-checking bench for riscv_ifetch: behavioural imem plus a scoreboard of
// expected decode transfers, and per-scenario cycle-exact checks.
module tb_riscv_ifetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr, imem_data, target, instr, pc, pc4;
    logic        imem_rd, redirect, valid, ready, mis;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    riscv_ifetch #(.RESET_PC(32'h0000_0000)) dut (
        .i_clock           (clk),
        .i_reset           (rst),
        .o_imem_addr       (imem_addr),
        .o_imem_rd         (imem_rd),
        .i_imem_data       (imem_data),
        .i_redirect_valid  (redirect),
        .i_redirect_target (target),
        .o_valid           (valid),
        .i_ready           (ready),
        .o_instr           (instr),
        .o_pc              (pc),
        .o_pc_plus4        (pc4),
        .o_misaligned      (mis)
    );

    // Memory image: words 0..3 are ADDI x1..x4, everything else a pc-derived pattern
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        logic [31:0] idx;
        idx = (a >> 2) + 32'd1;
        if (a < 32'd16) return {idx[11:0], 5'd0, 3'd0, idx[4:0], 7'h13};
        else return a ^ 32'h5A5A_0001;
    endfunction

    // Synchronous imem, one-cycle read latency
    always @(posedge clk) begin
        if (imem_rd === 1'b1) imem_data <= imem_word(imem_addr);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input logic [31:0] p);
        exp_t e;
        e.pc = p; e.instr = imem_word(p); e.mis = 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic sb_push_mis(input logic [31:0] p);
        exp_t e;
        e.pc = p; e.instr = NOP; e.mis = 1'b1;
        sb_q.push_back(e);
    endtask

    task automatic scoreboard_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid === 1'b1 && ready === 1'b1) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected got pc=%h instr=%h required no transfer", pc, instr);
                end else begin
                    e = sb_q.pop_front();
                    if (pc !== e.pc || instr !== e.instr || mis !== e.mis || pc4 !== e.pc + 32'd4) begin
                        n_err++;
                        $display("FAIL sb_xfer got pc=%h instr=%h mis=%b pc4=%h required pc=%h instr=%h mis=%b pc4=%h",
                                 pc, instr, mis, pc4, e.pc, e.instr, e.mis, e.pc + 32'd4);
                    end
                end
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (sb_q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        ready = 1'b0;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain got %0d pending required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset_stream();
        rst = 1'b1; ready = 1'b1; redirect = 1'b0; target = 32'h0;
        repeat (2) next_cycle();
        @(negedge clk);
        n_cmp++;
        if (valid !== 1'b0 || instr !== NOP || pc !== 32'h0 || pc4 !== 32'h0 || mis !== 1'b0 || imem_rd !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state got v=%b instr=%h pc=%h pc4=%h mis=%b rd=%b required 0 00000013 0 0 0 0",
                     valid, instr, pc, pc4, mis, imem_rd);
        end
        for (int i = 0; i < 4; i++) sb_push(32'(i * 4));
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (valid !== 1'b0 || imem_rd !== 1'b1 || imem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL first_fetch got v=%b rd=%b addr=%h required v=0 rd=1 addr=0", valid, imem_rd, imem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            @(negedge clk);
            n_cmp++;
            if (valid !== 1'b1 || pc !== 32'(i * 4)) begin
                n_err++;
                $display("FAIL stream_cycle%0d got v=%b pc=%h required v=1 pc=%h", i + 2, valid, pc, 32'(i * 4));
            end
        end
        next_cycle();
        ready = 1'b0;
    endtask

    task automatic test_stall();
        for (int k = 0; k < 3; k++) begin
            if (k != 0) next_cycle();
            @(negedge clk);
            n_cmp++;
            if (valid !== 1'b1 || pc !== 32'h10 || instr !== imem_word(32'h10) || mis !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold%0d got v=%b pc=%h instr=%h required v=1 pc=00000010 instr=%h",
                         k, valid, pc, instr, imem_word(32'h10));
            end
        end
        for (int i = 4; i < 9; i++) sb_push(32'(i * 4));
        next_cycle();
        ready = 1'b1;
        wait_drain("stall");
    endtask

    task automatic test_redirect();
        next_cycle();
        redirect = 1'b1; target = 32'h0;
        sb_push(32'h0); sb_push(32'h4); sb_push(32'h40); sb_push(32'h44); sb_push(32'h48);
        next_cycle();
        redirect = 1'b0; ready = 1'b1;
        repeat (2) next_cycle();
        next_cycle();
        ready = 1'b0; redirect = 1'b1; target = 32'h40;
        @(negedge clk);
        n_cmp++;
        if (valid !== 1'b1 || pc !== 32'h8) begin
            n_err++;
            $display("FAIL redir_pending got v=%b pc=%h required v=1 pc=00000008", valid, pc);
        end
        next_cycle();
        redirect = 1'b0; ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (valid !== 1'b0 || imem_rd !== 1'b1 || imem_addr !== 32'h40) begin
            n_err++;
            $display("FAIL redir_fetch got v=%b rd=%b addr=%h required v=0 rd=1 addr=00000040", valid, imem_rd, imem_addr);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (valid !== 1'b1 || pc !== 32'h40) begin
            n_err++;
            $display("FAIL redir_target got v=%b pc=%h required v=1 pc=00000040", valid, pc);
        end
        wait_drain("redirect");
    endtask

    task automatic test_misaligned();
        next_cycle();
        redirect = 1'b1; target = 32'h42;
        sb_push_mis(32'h42);
        next_cycle();
        redirect = 1'b0; ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (imem_rd !== 1'b0 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL mis_noread got rd=%b v=%b required rd=0 v=0", imem_rd, valid);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (valid !== 1'b1 || mis !== 1'b1 || instr !== NOP || pc !== 32'h42) begin
            n_err++;
            $display("FAIL mis_present got v=%b mis=%b instr=%h pc=%h required v=1 mis=1 instr=00000013 pc=00000042",
                     valid, mis, instr, pc);
        end
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            @(negedge clk);
            n_cmp++;
            if (imem_rd !== 1'b0 || valid !== 1'b0) begin
                n_err++;
                $display("FAIL mis_halt%0d got rd=%b v=%b required rd=0 v=0", k, imem_rd, valid);
            end
        end
        wait_drain("misaligned");
    endtask

    task automatic test_wrap();
        next_cycle();
        redirect = 1'b1; target = 32'hFFFF_FFFC;
        sb_push(32'hFFFF_FFFC); sb_push(32'h0); sb_push(32'h4);
        next_cycle();
        redirect = 1'b0; ready = 1'b1;
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (valid !== 1'b1 || pc !== 32'hFFFF_FFFC || pc4 !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_top got v=%b pc=%h pc4=%h required v=1 pc=fffffffc pc4=00000000", valid, pc, pc4);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (valid !== 1'b1 || pc !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_next got v=%b pc=%h required v=1 pc=00000000", valid, pc);
        end
        wait_drain("wrap");
    endtask

    task automatic test_reset_skid();
        next_cycle();
        redirect = 1'b1; target = 32'h0;
        next_cycle();
        redirect = 1'b0;
        repeat (3) next_cycle();
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (valid !== 1'b1 || pc !== 32'h0 || imem_rd !== 1'b0) begin
            n_err++;
            $display("FAIL skid_full got v=%b pc=%h rd=%b required v=1 pc=00000000 rd=0", valid, pc, imem_rd);
        end
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (imem_rd !== 1'b0) begin
            n_err++;
            $display("FAIL rst_rd got rd=%b required 0", imem_rd);
        end
        next_cycle();
        rst = 1'b0; ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (valid !== 1'b0 || imem_rd !== 1'b1 || imem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL rst_restart got v=%b rd=%b addr=%h required v=0 rd=1 addr=0", valid, imem_rd, imem_addr);
        end
        sb_push(32'h0); sb_push(32'h4); sb_push(32'h8);
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (valid !== 1'b1 || pc !== 32'h0 || instr !== imem_word(32'h0)) begin
            n_err++;
            $display("FAIL rst_first got v=%b pc=%h instr=%h required v=1 pc=0 instr=%h", valid, pc, instr, imem_word(32'h0));
        end
        wait_drain("reset_skid");
    endtask

    initial begin
        rst = 1'b1; ready = 1'b1; redirect = 1'b0; target = 32'h0;
        fork
            scoreboard_monitor();
        join_none
        test_reset_stream();
        test_stall();
        test_redirect();
        test_misaligned();
        test_wrap();
        test_reset_skid();
        repeat (3) next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
